// File: rtl/adder_seq_chunked.sv
// Multi-cycle adder/subtractor that consumes ChunkWidth bits per clock, rippling
// the carry between chunks so only a narrow adder sits in the critical path.
module adder_seq_chunked #(
    parameter int Width      = 8,
    parameter int ChunkWidth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [Width-1:0] suma,
    output logic             cout,
    output logic             overflow
);

    localparam int N    = Width / ChunkWidth;
    localparam int IdxW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic                 accept_s;
    logic                 last_s;
    logic [Width-1:0]     a_r;
    logic [Width-1:0]     b_r;
    logic                 carry_r;
    logic [IdxW-1:0]      idx_r;
    logic [Width-1:0]     res_r;
    logic [Width-1:0]     res_next_s;
    logic [ChunkWidth-1:0] a_chunk_s;
    logic [ChunkWidth-1:0] b_chunk_s;
    logic [ChunkWidth:0]   chunk_sum_s;

    assign last_s = (idx_r == IdxW'(N - 1));

    // Next-state logic; a start is only honoured outside CALC
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_next_s = CALC;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // One chunk of the addition, merged into the partial result
    always_comb begin
        a_chunk_s   = a_r[idx_r*ChunkWidth +: ChunkWidth];
        b_chunk_s   = b_r[idx_r*ChunkWidth +: ChunkWidth];
        chunk_sum_s = {1'b0, a_chunk_s} + {1'b0, b_chunk_s}
                    + {{ChunkWidth{1'b0}}, carry_r};
        res_next_s  = res_r;
        res_next_s[idx_r*ChunkWidth +: ChunkWidth] = chunk_sum_s[ChunkWidth-1:0];
    end

    // State, operand latch, chunk sequencing and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            a_r      <= {Width{1'b0}};
            b_r      <= {Width{1'b0}};
            carry_r  <= 1'b0;
            idx_r    <= {IdxW{1'b0}};
            res_r    <= {Width{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            suma     <= {Width{1'b0}};
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy    <= (state_next_s == CALC);
            done    <= (state_next_s == DONE);
            if (accept_s) begin
                a_r     <= a;
                // Subtraction is a + ~b + 1, the +1 entering as the initial carry
                b_r     <= mode ? ~b : b;
                carry_r <= mode;
                idx_r   <= {IdxW{1'b0}};
            end else if (state_r == CALC) begin
                res_r   <= res_next_s;
                carry_r <= chunk_sum_s[ChunkWidth];
                idx_r   <= last_s ? {IdxW{1'b0}} : (idx_r + IdxW'(1));
                // Only the completed sum is published, never a partial one
                if (last_s) begin
                    suma     <= res_next_s;
                    cout     <= chunk_sum_s[ChunkWidth];
                    overflow <= (a_r[Width-1] == b_r[Width-1]) &&
                                (res_next_s[Width-1] != a_r[Width-1]);
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_seq_chunked.sv
// Directed bench for adder_seq_chunked (Width=8, ChunkWidth=4): expected results
// are queued at start and compared when done pulses.
module tb_adder_seq_chunked;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int N  = W / CW;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] suma;
    logic         cout;
    logic         overflow;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    adder_seq_chunked #(.Width(W), .ChunkWidth(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .suma     (suma),
        .cout     (cout),
        .overflow (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
        logic [W-1:0] yb;
        logic [W:0]   t;
        exp_t         r;
        yb  = m ? ~y : y;
        t   = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, m};
        r.s = t[W-1:0];
        r.c = t[W];
        r.v = (x[W-1] == yb[W-1]) && (t[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
        start = 1'b1;
        a     = x;
        b     = y;
        mode  = m;
        sbq.push_back(model(x, y, m));
    endtask

    task automatic wait_done(input string tag, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic check_result(input string tag, output exp_t e);
        e = '0;
        if (sbq.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_suma"}, {24'd0, suma}, {24'd0, e.s});
            chk({tag, "_cout"}, {31'd0, cout}, {31'd0, e.c});
            chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, e.v});
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic m);
        int   lat;
        int   bc;
        exp_t e;
        drive_start(x, y, m);
        tick();
        start = 1'b0;
        wait_done(tag, lat, bc);
        chk({tag, "_latency"}, lat, N);
        chk({tag, "_busy_cycles"}, bc, N);
        check_result(tag, e);
        tick();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_hold"}, {24'd0, suma}, {24'd0, e.s});
    endtask

    initial begin
        int         lat;
        int         bc;
        int         dcnt;
        exp_t       e;
        exp_t       prev;
        logic [W-1:0] ops_a [3];
        logic [W-1:0] ops_b [3];

        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_suma", {24'd0, suma}, 32'd0);
        chk("reset_cout", {31'd0, cout}, 32'd0);
        chk("reset_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        tick();

        run_op("add", 8'h3C, 8'h55, 1'b0);
        run_op("add_wrap", 8'hFF, 8'h01, 1'b0);
        run_op("sub_borrow", 8'h10, 8'h20, 1'b1);
        run_op("sub_ovf", 8'h80, 8'h01, 1'b1);

        // start pulsed during CALC must be ignored
        drive_start(8'h01, 8'h01, 1'b0);
        tick();
        chk("ign_busy0", {31'd0, busy}, 32'd1);
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h11;
        tick();
        start = 1'b0;
        chk("ign_busy1", {31'd0, busy}, 32'd1);
        chk("ign_nodone", {31'd0, done}, 32'd0);
        tick();
        chk("ign_done", {31'd0, done}, 32'd1);
        chk("ign_busy_low", {31'd0, busy}, 32'd0);
        check_result("ign", e);
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || busy) dcnt++;
        end
        chk("ign_no_restart", dcnt, 0);

        // back-to-back: new start accepted in the DONE cycle
        ops_a[0] = 8'h12; ops_b[0] = 8'h34;
        ops_a[1] = 8'hF0; ops_b[1] = 8'h0F;
        ops_a[2] = 8'h99; ops_b[2] = 8'h77;
        drive_start(ops_a[0], ops_b[0], 1'b0);
        tick();
        start = 1'b0;
        wait_done("b2b0", lat, bc);
        check_result("b2b0", prev);
        for (int i = 1; i < 3; i++) begin
            drive_start(ops_a[i], ops_b[i], i[0]);
            tick();
            start = 1'b0;
            chk("b2b_hold", {24'd0, suma}, {24'd0, prev.s});
            chk("b2b_busy", {31'd0, busy}, 32'd1);
            wait_done("b2b", lat, bc);
            chk("b2b_spacing", lat + 1, N + 1);
            check_result("b2b", prev);
        end
        tick();

        // reset asserted in the first CALC cycle
        drive_start(8'h55, 8'h22, 1'b0);
        tick();
        start = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        sbq.delete();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_suma", {24'd0, suma}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done || busy) dcnt++;
        end
        chk("rst_no_done", dcnt, 0);

        // reset wins over a simultaneous start
        rst = 1'b1;
        drive_start(8'h01, 8'h02, 1'b0);
        tick();
        rst   = 1'b0;
        start = 1'b0;
        sbq.delete();
        chk("rst_prio_busy", {31'd0, busy}, 32'd0);
        tick();

        run_op("post_rst", 8'h7F, 8'h01, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
